// File: rtl/avalon_ibex_arbiter.sv
// Two-to-one Avalon-MM arbiter that merges the ibex instruction and data masters onto one fabric port.
// Define AVALON_ARB_RR_EN for round-robin arbitration; the default is fixed priority, with data over instruction.
module avalon_ibex_arbiter #(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned AddrWidth      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] avs_instr_address,
  input  logic                 avs_instr_read,
  output logic [31:0]          avs_instr_readdata,
  output logic                 avs_instr_waitrequest,
  output logic                 avs_instr_readdatavalid,
  input  logic [AddrWidth-1:0] avs_data_address,
  input  logic [3:0]           avs_data_byteenable,
  input  logic                 avs_data_read,
  input  logic                 avs_data_write,
  input  logic [31:0]          avs_data_writedata,
  output logic [31:0]          avs_data_readdata,
  output logic                 avs_data_waitrequest,
  output logic                 avs_data_readdatavalid,
  output logic [1:0]           avs_data_response,
  output logic [AddrWidth-1:0] avm_address,
  output logic [3:0]           avm_byteenable,
  output logic                 avm_read,
  output logic                 avm_write,
  output logic [31:0]          avm_writedata,
  input  logic [31:0]          avm_readdata,
  input  logic                 avm_waitrequest,
  input  logic                 avm_readdatavalid,
  input  logic [1:0]           avm_response,
  output logic                 err_o
);

  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q;
  logic              owner_q;   // 1 = data port
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              err_q, err_d;
  logic              fifo_q [MaxOutstanding];

  logic rd_ok, instr_req, data_req, gnt_valid, gnt_data;
  logic cmd, accept, push, pop, head;

`ifdef AVALON_ARB_RR_EN
  logic prio_q, prio_d;  // 1 = data holds priority
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    rd_ok     = count_q < CntW'(MaxOutstanding);
    instr_req = avs_instr_read & rd_ok;
    data_req  = avs_data_write | (avs_data_read & rd_ok);
    gnt_valid = 1'b0;
    gnt_data  = 1'b0;
    // The grant is held off during reset, so every output shows its reset value while rst_i is high.
    if (!rst_i) begin
      if (state_q == LOCKED) begin
        gnt_valid = 1'b1;
        gnt_data  = owner_q;
      end else begin
`ifdef AVALON_ARB_RR_EN
        if (data_req && instr_req) begin
          gnt_valid = 1'b1;
          gnt_data  = prio_q;
        end else if (data_req) begin
          gnt_valid = 1'b1;
          gnt_data  = 1'b1;
        end else if (instr_req) begin
          gnt_valid = 1'b1;
        end
`else
        if (data_req) begin
          gnt_valid = 1'b1;
          gnt_data  = 1'b1;
        end else if (instr_req) begin
          gnt_valid = 1'b1;
        end
`endif
      end
    end
  end

  assign avm_read       = gnt_valid & (gnt_data ? (avs_data_read & ~avs_data_write) : avs_instr_read);
  assign avm_write      = gnt_valid & gnt_data & avs_data_write;
  assign avm_address    = !gnt_valid ? '0 : (gnt_data ? avs_data_address : avs_instr_address);
  assign avm_byteenable = !gnt_valid ? 4'h0 : (gnt_data ? avs_data_byteenable : 4'hF);
  assign avm_writedata  = (gnt_valid & gnt_data) ? avs_data_writedata : 32'h0;

  assign avs_instr_waitrequest = ~(gnt_valid & ~gnt_data) | avm_waitrequest;
  assign avs_data_waitrequest  = ~(gnt_valid &  gnt_data) | avm_waitrequest;

  assign cmd    = avm_read | avm_write;
  assign accept = cmd & ~avm_waitrequest;
  assign push   = avm_read & ~avm_waitrequest;
  assign pop    = ~rst_i & avm_readdatavalid & (count_q != '0);
  assign head   = fifo_q[rd_ptr_q];

  assign avs_instr_readdatavalid = pop & ~head;
  assign avs_data_readdatavalid  = pop & head;
  assign avs_instr_readdata      = avm_readdata;
  assign avs_data_readdata       = avm_readdata;
  assign avs_data_response       = avm_response;
  assign err_o                   = err_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CntW'(1);
    if (pop && !push) count_d = count_q - CntW'(1);
    // A response with nothing outstanding is dropped and flagged until reset.
    err_d    = err_q | (~rst_i & avm_readdatavalid & (count_q == '0));
`ifdef AVALON_ARB_RR_EN
    prio_d   = (accept && (gnt_data == prio_q)) ? ~prio_q : prio_q;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd && avm_waitrequest) begin
            state_q <= LOCKED;
            owner_q <= gnt_data;
          end
        end
        LOCKED: begin
          if (accept || !cmd) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
`ifdef AVALON_ARB_RR_EN
      prio_q   <= 1'b1;
`endif
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
`ifdef AVALON_ARB_RR_EN
      prio_q   <= prio_d;
`endif
    end
  end

  // NOTE: the source-ID storage has no reset; count_q and the pointers decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= gnt_data;
  end

endmodule

// File: tb/tb_avalon_ibex_arbiter.sv
// Self-checking bench for avalon_ibex_arbiter: directed stimulus with a scoreboard of expected read responses.
module tb_avalon_ibex_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] avs_instr_address;
  logic        avs_instr_read;
  logic [31:0] avs_instr_readdata;
  logic        avs_instr_waitrequest, avs_instr_readdatavalid;
  logic [31:0] avs_data_address;
  logic [3:0]  avs_data_byteenable;
  logic        avs_data_read, avs_data_write;
  logic [31:0] avs_data_writedata, avs_data_readdata;
  logic        avs_data_waitrequest, avs_data_readdatavalid;
  logic [1:0]  avs_data_response;
  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [1:0]  avm_response;
  logic        err_o;

  typedef struct {
    logic        port;  // 1 = data
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_i = ~clk_i;

  avalon_ibex_arbiter #(.MaxOutstanding(4), .AddrWidth(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .avs_instr_address(avs_instr_address), .avs_instr_read(avs_instr_read),
    .avs_instr_readdata(avs_instr_readdata), .avs_instr_waitrequest(avs_instr_waitrequest),
    .avs_instr_readdatavalid(avs_instr_readdatavalid),
    .avs_data_address(avs_data_address), .avs_data_byteenable(avs_data_byteenable),
    .avs_data_read(avs_data_read), .avs_data_write(avs_data_write),
    .avs_data_writedata(avs_data_writedata), .avs_data_readdata(avs_data_readdata),
    .avs_data_waitrequest(avs_data_waitrequest), .avs_data_readdatavalid(avs_data_readdatavalid),
    .avs_data_response(avs_data_response),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .avm_response(avm_response), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
    avm_readdatavalid = 1'b0;
    avm_response      = 2'b00;
  endtask

  task automatic clear_inputs();
    avs_instr_address = '0; avs_instr_read = 0;
    avs_data_address = '0; avs_data_byteenable = '0; avs_data_read = 0;
    avs_data_write = 0; avs_data_writedata = '0;
    avm_readdata = '0; avm_waitrequest = 0; avm_readdatavalid = 0; avm_response = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_inputs();
    next();
    next();
    rst_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic [1:0] resp);
    avm_readdatavalid = 1'b1;
    avm_readdata      = data;
    avm_response      = resp;
    settle();
    next();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_wr"}, {avm_read, avm_write}, 2'b00);
    check({tag, "_addr"}, avm_address, 32'h0);
    check({tag, "_be_wd"}, {avm_byteenable, avm_writedata}, 36'h0);
    check({tag, "_wait"}, {avs_data_waitrequest, avs_instr_waitrequest}, 2'b11);
    check({tag, "_valid"}, {avs_data_readdatavalid, avs_instr_readdatavalid}, 2'b00);
    check({tag, "_err"}, err_o, 1'b0);
  endtask

  // Scoreboard: every slave-side valid pulse must match the oldest expected response.
  always @(negedge clk_i) begin
    if (!rst_i && (avs_instr_readdatavalid || avs_data_readdatavalid)) begin
      if (exp_q.size() == 0) begin
        check("rdv_unexpected", {avs_data_readdatavalid, avs_instr_readdatavalid}, 2'b00);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rdv_port", {avs_data_readdatavalid, avs_instr_readdatavalid}, e.port ? 2'b10 : 2'b01);
        check("rdv_data", e.port ? avs_data_readdata : avs_instr_readdata, e.data);
        if (e.port) check("rdv_resp", avs_data_response, e.resp);
      end
    end
  end

  initial begin
    logic [31:0] issued [4];
    logic        g;

    rst_i = 1'b1;
    clear_inputs();
    next();
    settle();
    check_reset_outputs("reset");
    next();
    rst_i = 1'b0;

    // Instr read held under waitrequest; a data write arriving meanwhile must not steal the grant.
    avs_instr_read = 1; avs_instr_address = 32'h100;
    for (int i = 0; i < 3; i++) begin
      avm_waitrequest = (i < 2);
      if (i == 1) begin
        avs_data_write = 1; avs_data_address = 32'h80; avs_data_writedata = 32'h0BAD_F00D;
        avs_data_byteenable = 4'hF;
      end
      settle();
      check("t1_addr", avm_address, 32'h100);
      check("t1_read", {avm_read, avm_write}, 2'b10);
      check("t1_iwait", avs_instr_waitrequest, (i < 2));
      if (i >= 1) check("t1_dwait", avs_data_waitrequest, 1'b1);
      next();
    end
    exp_q.push_back('{port: 1'b0, data: 32'hDEAD_BEEF, resp: 2'b00});
    avs_instr_read = 0; avm_waitrequest = 0;
    settle();
    check("t1_write_after", {avm_write, avm_address}, {1'b1, 32'h80});
    next();
    avs_data_write = 0;
    settle();
    next();
    respond(32'hDEAD_BEEF, 2'b00);

    // Both ports reading every cycle with a fabric that never stalls.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      avs_instr_read = 1; avs_instr_address = 32'h300 + 32'(16 * k);
      avs_data_read  = 1; avs_data_address  = 32'h200 + 32'(16 * k); avs_data_byteenable = 4'hF;
`ifdef AVALON_ARB_RR_EN
      g = (k % 2 == 0);
`else
      g = 1'b1;
`endif
      settle();
      check("t2_addr", avm_address, g ? 32'h200 + 32'(16 * k) : 32'h300 + 32'(16 * k));
      check("t2_wait", {avs_data_waitrequest, avs_instr_waitrequest}, g ? 2'b01 : 2'b10);
      issued[k] = 32'h1000_0000 + 32'(k);
      exp_q.push_back('{port: g, data: issued[k], resp: 2'b00});
      next();
    end
    avs_instr_read = 0; avs_data_read = 0;
    for (int k = 0; k < 4; k++) respond(issued[k], 2'b00);

    // FIFO full: reads stall, a write proceeds, a pop does not unblock the same cycle.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      avs_instr_read = 1; avs_instr_address = 32'h400 + 32'(4 * k);
      settle();
      check("t3_issue", {avs_instr_waitrequest, avm_read}, 2'b01);
      exp_q.push_back('{port: 1'b0, data: 32'h3000_0000 + 32'(k), resp: 2'b00});
      next();
    end
    avs_instr_address = 32'h410; avs_data_read = 1; avs_data_address = 32'h500;
    settle();
    check("t3_full_wait", {avs_data_waitrequest, avs_instr_waitrequest, avm_read}, 3'b110);
    next();
    avs_data_read = 0; avs_data_write = 1; avs_data_address = 32'h40;
    avs_data_writedata = 32'hCAFE_0040; avs_data_byteenable = 4'h3;
    settle();
    check("t3_write", {avm_write, avm_read, avm_address}, {2'b10, 32'h40});
    check("t3_wdata", {avm_byteenable, avm_writedata}, {4'h3, 32'hCAFE_0040});
    check("t3_wait", {avs_data_waitrequest, avs_instr_waitrequest}, 2'b01);
    next();
    avs_data_write = 0;
    avm_readdatavalid = 1; avm_readdata = 32'h3000_0000;
    settle();
    check("t3_no_bypass", {avs_instr_waitrequest, avm_read}, 2'b10);
    next();
    settle();
    check("t3_unblock", {avs_instr_waitrequest, avm_read, avm_address}, {2'b01, 32'h410});
    exp_q.push_back('{port: 1'b0, data: 32'h3000_0004, resp: 2'b00});
    next();
    avs_instr_read = 0;
    for (int k = 1; k < 5; k++) respond(32'h3000_0000 + 32'(k), 2'b00);

    // Data read returning an error response.
    do_reset();
    avs_data_read = 1; avs_data_address = 32'h500; avs_data_byteenable = 4'hC;
    settle();
    check("t4_cmd", {avs_data_waitrequest, avm_read, avm_byteenable}, {2'b01, 4'hC});
    exp_q.push_back('{port: 1'b1, data: 32'h5555_AAAA, resp: 2'b10});
    next();
    avs_data_read = 0;
    respond(32'h5555_AAAA, 2'b10);

    // Stray response with nothing outstanding.
    avm_readdatavalid = 1; avm_readdata = 32'h1234_5678;
    settle();
    check("t5_no_valid", {avs_data_readdatavalid, avs_instr_readdatavalid}, 2'b00);
    next();
    settle();
    check("t5_err_set", err_o, 1'b1);
    for (int i = 0; i < 3; i++) next();
    settle();
    check("t5_err_sticky", err_o, 1'b1);
    do_reset();
    settle();
    check("t5_err_clear", err_o, 1'b0);

    // Reset with reads outstanding and a locked, stalled write.
    next();
    for (int k = 0; k < 3; k++) begin
      avs_instr_read = 1; avs_instr_address = 32'h600 + 32'(4 * k);
      next();
    end
    avs_instr_read = 0;
    avs_data_write = 1; avs_data_address = 32'h60; avs_data_writedata = 32'h6060_6060;
    avs_data_byteenable = 4'hF; avm_waitrequest = 1;
    settle();
    check("t6_locked", {avm_write, avs_data_waitrequest}, 2'b11);
    next();
    rst_i = 1; avs_instr_read = 1; avs_instr_address = 32'h700;
    next();
    settle();
    check_reset_outputs("t6_reset");
    next();
    rst_i = 0; avs_instr_read = 0; avs_data_write = 0; avm_waitrequest = 0;
    avm_readdatavalid = 1; avm_readdata = 32'h0000_0600;
    settle();
    check("t6_late_rsp", {avs_data_readdatavalid, avs_instr_readdatavalid}, 2'b00);
    next();
    avs_instr_read = 1; avs_instr_address = 32'h700;
    settle();
    check("t6_count0_err", err_o, 1'b1);
    check("t6_released", {avs_instr_waitrequest, avm_read, avm_address}, {2'b01, 32'h700});
    exp_q.push_back('{port: 1'b0, data: 32'h7777_7777, resp: 2'b00});
    next();
    avs_instr_read = 0;
    respond(32'h7777_7777, 2'b00);

    next();
    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/avalon_ibex_arbiter.md
# avalon_ibex_arbiter

Two-to-one Avalon-MM arbiter that lets the ibex instruction and data Avalon masters share a single Avalon-MM master port into a unified memory or fabric. It sits between the two ibex Avalon translators and the system interconnect. It accepts pipelined reads from both sides, keeps a source-ID FIFO of outstanding reads, and routes in-order `readdatavalid` responses back to the originating port. Writes complete on acceptance.

## Interface
Parameters:
- `MaxOutstanding`, default 4: maximum in-flight reads; power of two, 2..16.
- `AddrWidth`, default 32: address width on all ports.

Ports:
- `clk_i`  in  1  single clock for the whole block.
- `rst_i`  in  1  synchronous, active-high reset.
- `avs_instr_address`  in  AddrWidth  instruction-side read address.
- `avs_instr_read`  in  1  instruction read request.
- `avs_instr_readdata`  out  32  routed read data.
- `avs_instr_waitrequest`  out  1  stall to instruction master.
- `avs_instr_readdatavalid`  out  1  instruction read data valid.
- `avs_data_address`  in  AddrWidth  data-side address.
- `avs_data_byteenable`  in  4  data byte enables.
- `avs_data_read`  in  1  data read request.
- `avs_data_write`  in  1  data write request.
- `avs_data_writedata`  in  32  write data.
- `avs_data_readdata`  out  32  routed read data.
- `avs_data_waitrequest`  out  1  stall to data master.
- `avs_data_readdatavalid`  out  1  data read data valid.
- `avs_data_response`  out  2  routed response code.
- `avm_address`  out  AddrWidth  shared master address.
- `avm_byteenable`  out  4  shared byte enables; 4'hF for instruction reads.
- `avm_read`  out  1  shared read strobe.
- `avm_write`  out  1  shared write strobe.
- `avm_writedata`  out  32  shared write data.
- `avm_readdata`  in  32  fabric read data.
- `avm_waitrequest`  in  1  fabric stall.
- `avm_readdatavalid`  in  1  fabric read data valid.
- `avm_response`  in  2  fabric response.
- `err_o`  out  1  sticky protocol error: `readdatavalid` with no read outstanding.

## Operation
- The instruction port only reads. A data request with both `read` and `write` high is treated as a write.
- States:
  - IDLE: the grant is chosen combinationally each cycle from the eligible requests.
  - LOCKED: `owner` is registered and the grant holds.
- IDLE to LOCKED: a command is driven while `avm_waitrequest`=1 at the clock edge.
- LOCKED to IDLE: when that command is accepted.
- Acceptance: `(avm_read|avm_write) & ~avm_waitrequest`.
- Eligibility:
  - A read is eligible only when `count < MaxOutstanding`.
  - Writes are always eligible.
  - An ineligible requester sees waitrequest=1.
- Master outputs mirror the granted port. When nothing is granted, `avm_read`=`avm_write`=0 and address/data are 0.
- Waitrequest:
  - The granted port receives `avm_waitrequest`.
  - Every other port receives 1.
- Outstanding reads:
  - Each accepted read pushes its source ID (0=instr, 1=data) into the FIFO.
  - Each `avm_readdatavalid` pops the FIFO head and raises `readdatavalid` on the head's port only.
- `avm_readdata` fans out to both `readdata` outputs unconditionally. `avs_data_response` = `avm_response`.
- `count` has width $clog2(MaxOutstanding+1).
  - Simultaneous push and pop: `count` unchanged, FIFO pointers both advance.
  - Pointers wrap modulo MaxOutstanding.
- FIFO full: reads from both ports stall; writes still proceed; a pop in the same cycle does not unblock that cycle (no bypass).
- `avm_readdatavalid` with `count`==0: the response is dropped, no port sees valid, `err_o` sets. `err_o` clears only on reset.

## Timing
- Command path is combinational, zero added latency: a request is visible on `avm_*` in the same cycle.
- Response path is combinational: `readdatavalid` appears in the same cycle as `avm_readdatavalid`.
- A command under waitrequest stays stable on the master port until accepted. The grant never switches mid-command.
- Back-to-back accepted commands from alternating ports are permitted every cycle.
- Reset values:
  - `avm_read`=`avm_write`=0; `avm_address`, `avm_byteenable`, `avm_writedata` = 0.
  - Both slave waitrequests = 1; both `readdatavalid` = 0; `err_o`=0.
  - State IDLE, `count`=0, FIFO empty.
- Reset mid-operation: outstanding reads are forgotten. Late fabric responses then set `err_o`. The fabric must be reset together with this block.

## Configuration
- `AVALON_ARB_RR_EN` defined: round-robin arbitration.
  - A one-bit priority register flips to the other port after each accepted command from the current priority holder.
  - Resets to favour data.
- `AVALON_ARB_RR_EN` undefined: fixed priority, data over instruction.
  - Instruction is granted only when data is not eligibly requesting.

## Test plan
- Instr read 0x100, fabric waitrequest 2 cycles, data 0xDEADBEEF after 3 cycles -> address held for 3 cycles; only `avs_instr_readdatavalid` pulses, with `readdata`=0xDEADBEEF.
- Simultaneous instr and data reads every cycle, fabric never stalls -> fixed build issues only data reads while data requests. RR build alternates data/instr/data/instr. Responses return to the matching ports in issue order.
- Issue 4 instr reads with no responses (MaxOutstanding=4), then a data write to 0x40 -> a fifth read stalls while the write is accepted. The first `readdatavalid` pop allows the next read the following cycle.
- Data read with `avm_response`=2'b10 -> `avs_data_response`=2'b10 with the valid pulse; the instruction port is unaffected.
- `avm_readdatavalid` pulse with nothing outstanding -> no slave valid; `err_o`=1 until `rst_i`.
- Assert `rst_i` with 3 reads outstanding and a locked stalled write -> next cycle all outputs at reset values, `count`=0, the grant released.
